// File: rtl/hack_rom_loader.sv
// Hack ROM loader: packs the MiSTer ioctl byte stream into big-endian 16-bit ROM
// words, optionally zero-fills the ROM tail, and holds the CPU in reset until loading settles.
module hack_rom_loader #(
  parameter int ROM_WORDS   = 32768,
  parameter bit FILL_ENABLE = 1'b1,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        rom_we,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        cpu_reset,
  output logic        loaded,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2,
    ST_FILL = 2'd3
  } state_t;

  localparam logic [24:0] BYTE_LIMIT = 25'(2 * ROM_WORDS);
  localparam logic [14:0] LAST_WORD  = 15'(ROM_WORDS - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);

  state_t      state_r, state_s;
  logic [15:0] hold_cnt_r, hold_cnt_s;
  logic        dl_prev_r;
  logic        pending_r, pending_s;
  logic [7:0]  high_r, high_s;
  logic [14:0] pend_addr_r, pend_addr_s;
  logic [14:0] max_word_r, max_word_s;
  logic [14:0] fill_addr_r, fill_addr_s;
  logic        we_s, loaded_s;
  logic [14:0] addr_s;
  logic [15:0] wdata_s, count_s;
  logic        dl_rise_s, in_range_s;
  logic [14:0] word_addr_s, fin_max_s;
  logic [15:0] count_inc_s, fin_count_s;

  // Next-state, byte packing and write-port decode
  always_comb begin
    state_s     = state_r;
    hold_cnt_s  = hold_cnt_r;
    pending_s   = pending_r;
    high_s      = high_r;
    pend_addr_s = pend_addr_r;
    max_word_s  = max_word_r;
    fill_addr_s = fill_addr_r;
    we_s        = 1'b0;
    addr_s      = rom_addr;
    wdata_s     = rom_wdata;
    loaded_s    = loaded;
    count_s     = word_count;

    dl_rise_s   = ioctl_download & ~dl_prev_r;
    in_range_s  = (ioctl_addr < BYTE_LIMIT);
    word_addr_s = ioctl_addr[15:1];
    count_inc_s = (word_count == 16'hFFFF) ? word_count : word_count + 16'd1;
    // A dangling high byte at download end still counts as a word
    fin_count_s = pending_r ? count_inc_s : word_count;
    fin_max_s   = (pending_r && (pend_addr_r > max_word_r)) ? pend_addr_r : max_word_r;

    case (state_r)
      ST_HOLD: begin
        if (dl_rise_s) begin
          state_s    = ST_LOAD;
          count_s    = 16'd0;
          pending_s  = 1'b0;
          max_word_s = 15'd0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s = ST_RUN;
        end else begin
          hold_cnt_s = hold_cnt_r + 16'd1;
        end
      end
      ST_RUN: begin
        if (ioctl_download) begin
          state_s    = ST_LOAD;
          count_s    = 16'd0;
          pending_s  = 1'b0;
          max_word_s = 15'd0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (!ioctl_download) begin
          loaded_s   = 1'b1;
          count_s    = fin_count_s;
          max_word_s = fin_max_s;
          pending_s  = 1'b0;
          if (pending_r) begin
            we_s    = 1'b1;
            addr_s  = pend_addr_r;
            wdata_s = {high_r, 8'h00};
          end else begin
            we_s = 1'b0;
          end
          if (FILL_ENABLE && (fin_count_s != 16'd0) && (fin_max_s < LAST_WORD)) begin
            state_s     = ST_FILL;
            fill_addr_s = fin_max_s + 15'd1;
          end else begin
            state_s    = ST_HOLD;
            hold_cnt_s = 16'd0;
          end
        end else if (ioctl_wr && in_range_s) begin
          if (!ioctl_addr[0]) begin
            high_s      = ioctl_dout;
            pend_addr_s = word_addr_s;
            pending_s   = 1'b1;
          end else begin
            we_s       = 1'b1;
            addr_s     = word_addr_s;
            wdata_s    = {high_r, ioctl_dout};
            pending_s  = 1'b0;
            count_s    = count_inc_s;
            max_word_s = (word_addr_s > max_word_r) ? word_addr_s : max_word_r;
          end
        end else begin
          pending_s = pending_r;
        end
      end
      ST_FILL: begin
        // A new download abandons the fill; the new image gets its own fill later
        if (dl_rise_s) begin
          state_s    = ST_LOAD;
          count_s    = 16'd0;
          pending_s  = 1'b0;
          max_word_s = 15'd0;
        end else begin
          we_s    = 1'b1;
          addr_s  = fill_addr_r;
          wdata_s = 16'h0000;
          if (fill_addr_r == LAST_WORD) begin
            state_s    = ST_HOLD;
            hold_cnt_s = 16'd0;
          end else begin
            fill_addr_s = fill_addr_r + 15'd1;
          end
        end
      end
      default: begin
        state_s    = ST_HOLD;
        hold_cnt_s = 16'd0;
      end
    endcase
  end

  // State and registered outputs; the ROM itself is outside and survives reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_HOLD;
      hold_cnt_r  <= 16'd0;
      dl_prev_r   <= 1'b0;
      pending_r   <= 1'b0;
      high_r      <= 8'h00;
      pend_addr_r <= 15'd0;
      max_word_r  <= 15'd0;
      fill_addr_r <= 15'd0;
      rom_we      <= 1'b0;
      rom_addr    <= 15'd0;
      rom_wdata   <= 16'h0000;
      cpu_reset   <= 1'b1;
      loaded      <= 1'b0;
      word_count  <= 16'd0;
    end else begin
      state_r     <= state_s;
      hold_cnt_r  <= hold_cnt_s;
      dl_prev_r   <= ioctl_download;
      pending_r   <= pending_s;
      high_r      <= high_s;
      pend_addr_r <= pend_addr_s;
      max_word_r  <= max_word_s;
      fill_addr_r <= fill_addr_s;
      rom_we      <= we_s;
      rom_addr    <= addr_s;
      rom_wdata   <= wdata_s;
      cpu_reset   <= (state_r != ST_RUN);
      loaded      <= loaded_s;
      word_count  <= count_s;
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Bench for hack_rom_loader: a table of download scenarios (fixed and random payloads)
// checked against a byte-level ROM image model, plus hand-written abort/reset sequences.
`timescale 1ns/1ps
module tb_hack_rom_loader;
  localparam int ROM_WORDS     = 32768;
  localparam int HOLD_CYCLES   = 16;
  localparam int RELEASE_EDGES = HOLD_CYCLES + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic        loaded;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int bad_we = 0;

  logic [15:0] dut_rom   [ROM_WORDS];
  logic [15:0] model_rom [ROM_WORDS];
  bit any_byte;
  bit pend;
  int maxw;
  int pend_w;

  typedef struct {
    int          start;
    int          n;
    bit          rnd;
    logic [31:0] bytes;
    int          exp_words;
    int          exp_fill;
  } vec_t;
  vec_t tbl [7];

  hack_rom_loader #(.ROM_WORDS(ROM_WORDS), .FILL_ENABLE(1'b1), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .cpu_reset(cpu_reset), .loaded(loaded), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // ROM stand-in: records every write and flags writes while the CPU is running
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      dut_rom[rom_addr] <= rom_wdata;
      wr_total <= wr_total + 1;
      if (cpu_reset !== 1'b1) bad_we <= bad_we + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic new_model();
    any_byte = 1'b0;
    pend     = 1'b0;
    maxw     = 0;
    pend_w   = 0;
  endtask

  task automatic model_byte(input int a, input logic [7:0] d);
    if (a < 2 * ROM_WORDS) begin
      any_byte = 1'b1;
      if ((a >> 1) > maxw) maxw = a >> 1;
      if (a % 2 == 0) begin
        model_rom[a >> 1] = {d, 8'h00};
        pend = 1'b1;
        pend_w = a >> 1;
      end else begin
        model_rom[a >> 1][7:0] = d;
        pend = 1'b0;
      end
    end
  endtask

  task automatic model_fill();
    if (any_byte && maxw < ROM_WORDS - 1)
      for (int w = maxw + 1; w < ROM_WORDS; w++) model_rom[w] = 16'h0000;
  endtask

  task automatic check_image(input string name);
    int mism = 0;
    for (int w = 0; w < ROM_WORDS; w++)
      if (dut_rom[w] !== model_rom[w]) mism++;
    chk(name, mism, 0);
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    new_model();
  endtask

  task automatic send_byte(input int a, input logic [7:0] d, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    ioctl_wr = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    model_byte(a, d);
    if (a < 2 * ROM_WORDS && a % 2 == 1) begin
      chk("odd_we", rom_we, 1);
      chk("odd_addr", rom_addr, a >> 1);
      chk("odd_data", rom_wdata, model_rom[a >> 1]);
    end else begin
      chk("no_we", rom_we, 0);
    end
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    chk("end_we", rom_we, pend);
    if (pend) begin
      chk("end_addr", rom_addr, pend_w);
      chk("end_data", rom_wdata, model_rom[pend_w]);
    end
    chk("loaded", loaded, 1);
  endtask

  // Edges from the last write (or from entry) until cpu_reset falls
  task automatic wait_release(output int k);
    int guard = 0;
    k = 0;
    while (cpu_reset !== 1'b0 && guard < 40000) begin
      @(posedge clk); #1;
      guard++;
      if (rom_we === 1'b1) k = 0;
      else k++;
    end
    chk("release_bound", cpu_reset, 0);
  endtask

  task automatic run_case(input int id, input vec_t v);
    int w0;
    int k;
    logic [7:0] d;
    logic [31:0] b;
    b  = v.bytes;
    w0 = wr_total;
    start_dl();
    for (int i = 0; i < v.n; i++) begin
      d = v.rnd ? 8'($urandom_range(0, 255)) : b[31 - 8 * i -: 8];
      send_byte(v.start + i, d, $urandom_range(0, 2));
    end
    end_dl();
    model_fill();
    wait_release(k);
    chk($sformatf("words[%0d]", id), word_count, v.exp_words);
    chk($sformatf("writes[%0d]", id), wr_total - w0, v.exp_words + v.exp_fill);
    chk($sformatf("hold[%0d]", id), k, RELEASE_EDGES);
    check_image($sformatf("image[%0d]", id));
  endtask

  initial begin
    int k;
    int w0;
    bit found;
    vec_t v;
    int m;
    int mw;

    tbl[0] = '{0,     4, 1'b0, 32'hEA870010, 2, 32766};
    tbl[1] = '{65000, 3, 1'b1, 32'h0,        2, 266};
    tbl[2] = '{0,     0, 1'b1, 32'h0,        0, 0};
    tbl[3] = '{65534, 2, 1'b1, 32'h0,        1, 0};
    tbl[4] = '{65536, 2, 1'b1, 32'h0,        0, 0};
    tbl[5] = '{65534, 4, 1'b1, 32'h0,        1, 0};
    tbl[6] = '{65200, 1, 1'b1, 32'h0,        1, 167};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", rom_we, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_loaded", loaded, 0);
    chk("rst_count", word_count, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_wdata", rom_wdata, 0);
    reset = 1'b0;
    w0 = wr_total;
    wait_release(k);
    chk("por_release", k, RELEASE_EDGES);
    chk("por_writes", wr_total - w0, 0);
    chk("por_loaded", loaded, 0);

    // Odd-length download, then a new download aborts the fill at word 100
    start_dl();
    send_byte(0, 8'h12, 0);
    send_byte(1, 8'h34, 1);
    chk("word0", rom_wdata, 16'h1234);
    send_byte(2, 8'h56, 0);
    end_dl();
    chk("word1", rom_wdata, 16'h5600);
    chk("odd_len_words", word_count, 2);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk); #1;
      if (rom_we === 1'b1 && rom_addr == 15'd100) found = 1'b1;
    end
    chk("fill_reach_100", found, 1);
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    chk("abort_we", rom_we, 0);
    chk("abort_cpu_reset", cpu_reset, 1);
    chk("abort_count", word_count, 0);
    for (int w = 2; w <= 100; w++) model_rom[w] = 16'h0000;
    new_model();
    w0 = wr_total;
    for (int i = 0; i < 4; i++) send_byte(65000 + i, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
    end_dl();
    model_fill();
    wait_release(k);
    chk("abort_words", word_count, 2);
    chk("abort_writes", wr_total - w0, 268);
    chk("abort_hold", k, RELEASE_EDGES);
    check_image("abort_image");

    for (int t = 0; t < 7; t++) begin
      run_case(t, tbl[t]);
      if (t == 0) begin
        chk("ea87", dut_rom[0], 16'hEA87);
        chk("0010", dut_rom[1], 16'h0010);
      end
    end

    // Random short downloads near the top of the ROM
    for (int r = 0; r < 4; r++) begin
      v.start = 2 * $urandom_range(32600, 32767);
      v.n     = $urandom_range(1, 8);
      v.rnd   = 1'b1;
      v.bytes = 32'h0;
      m  = (v.n < 65536 - v.start) ? v.n : 65536 - v.start;
      mw = (v.start + m - 1) / 2;
      v.exp_words = (m + 1) / 2;
      v.exp_fill  = ROM_WORDS - 1 - mw;
      run_case(10 + r, v);
    end

    // Reset in the middle of a download, colliding with an odd-byte strobe
    start_dl();
    for (int i = 0; i < 20; i++) send_byte(i, 8'($urandom_range(0, 255)), 0);
    chk("pre_reset_count", word_count, 10);
    send_byte(20, 8'hA5, 0);
    ioctl_wr = 1'b1; ioctl_addr = 25'd21; ioctl_dout = 8'h5A;
    reset = 1'b1; ioctl_download = 1'b0;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    chk("mid_rst_we", rom_we, 0);
    chk("mid_rst_cpu_reset", cpu_reset, 1);
    chk("mid_rst_loaded", loaded, 0);
    chk("mid_rst_count", word_count, 0);
    reset = 1'b0;
    w0 = wr_total;
    wait_release(k);
    chk("mid_rst_release", k, RELEASE_EDGES);
    chk("mid_rst_writes", wr_total - w0, 0);
    chk("mid_rst_loaded_after", loaded, 0);

    @(posedge clk); #1;
    chk("we_while_running", bad_we, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
